// File: rtl/csi2_packet_handler.sv
// CSI-2 packet-level parser: classifies headers as short/long and streams long payload with byte enables.
// Optional CRC footer consumption is enabled with the CSI2_CRC_FOOTER_EN macro.
module csi2_packet_handler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] data_i,
  input  logic        error_i,
  input  logic        error_corrected_i,
  output logic        short_pkt_valid_o,
  output logic [1:0]  short_pkt_v_channel_o,
  output logic [5:0]  short_pkt_data_type_o,
  output logic [15:0] short_pkt_data_field_o,
  output logic        long_pkt_header_valid_o,
  output logic [1:0]  long_pkt_v_channel_o,
  output logic [5:0]  long_pkt_data_type_o,
  output logic [15:0] long_pkt_word_cnt_o,
  output logic [31:0] long_pkt_payload_o,
  output logic        long_pkt_payload_valid_o,
  output logic [3:0]  long_pkt_payload_be_o
);

  typedef enum logic [0:0] {StIdle, StPayload} state_e;

`ifdef CSI2_CRC_FOOTER_EN
  localparam logic [16:0] FooterBytes = 17'd2;
`else
  localparam logic [16:0] FooterBytes = 17'd0;
`endif

  state_e      state_q, state_d;
  // 17 bits so WC plus footer bytes never wraps
  logic [16:0] rem_q, rem_d;

  logic        short_valid_q, short_valid_d;
  logic [1:0]  short_vc_q, short_vc_d;
  logic [5:0]  short_dt_q, short_dt_d;
  logic [15:0] short_field_q, short_field_d;
  logic        long_hdr_valid_q, long_hdr_valid_d;
  logic [1:0]  long_vc_q, long_vc_d;
  logic [5:0]  long_dt_q, long_dt_d;
  logic [15:0] long_wc_q, long_wc_d;
  logic [31:0] payload_q, payload_d;
  logic        payload_valid_q, payload_valid_d;
  logic [3:0]  payload_be_q, payload_be_d;

  logic        hdr_ok;
  logic [16:0] rem_load;
  logic [16:0] data_left;

  // Corrected ECC errors are accepted; only uncorrectable ones drop the header
  assign hdr_ok    = valid_i && !(error_i && !error_corrected_i);
  assign rem_load  = {1'b0, data_i[23:8]} + FooterBytes;
  assign data_left = (rem_q > FooterBytes) ? (rem_q - FooterBytes) : 17'd0;

  always_comb begin
    state_d          = state_q;
    rem_d            = rem_q;
    short_valid_d    = 1'b0;
    short_vc_d       = short_vc_q;
    short_dt_d       = short_dt_q;
    short_field_d    = short_field_q;
    long_hdr_valid_d = 1'b0;
    long_vc_d        = long_vc_q;
    long_dt_d        = long_dt_q;
    long_wc_d        = long_wc_q;
    payload_d        = 32'd0;
    payload_valid_d  = 1'b0;
    payload_be_d     = 4'd0;

    unique case (state_q)
      StIdle: begin
        if (hdr_ok) begin
          if (data_i[29:28] == 2'b00) begin
            short_valid_d = 1'b1;
            short_vc_d    = data_i[31:30];
            short_dt_d    = data_i[29:24];
            short_field_d = data_i[23:8];
          end else begin
            long_hdr_valid_d = 1'b1;
            long_vc_d        = data_i[31:30];
            long_dt_d        = data_i[29:24];
            long_wc_d        = data_i[23:8];
            rem_d            = rem_load;
            if (rem_load != 17'd0) state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (valid_i) begin
          if (data_left != 17'd0) begin
            payload_valid_d = 1'b1;
            payload_d       = data_i;
            if (data_left >= 17'd4) begin
              payload_be_d = 4'hF;
            end else begin
              case (data_left[1:0])
                2'd3:    payload_be_d = 4'h7;
                2'd2:    payload_be_d = 4'h3;
                2'd1:    payload_be_d = 4'h1;
                default: payload_be_d = 4'h0;
              endcase
            end
          end
          if (rem_q > 17'd4) begin
            rem_d = rem_q - 17'd4;
          end else begin
            rem_d   = 17'd0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= StIdle;
      rem_q            <= 17'd0;
      short_valid_q    <= 1'b0;
      short_vc_q       <= 2'd0;
      short_dt_q       <= 6'd0;
      short_field_q    <= 16'd0;
      long_hdr_valid_q <= 1'b0;
      long_vc_q        <= 2'd0;
      long_dt_q        <= 6'd0;
      long_wc_q        <= 16'd0;
      payload_q        <= 32'd0;
      payload_valid_q  <= 1'b0;
      payload_be_q     <= 4'd0;
    end else begin
      state_q          <= state_d;
      rem_q            <= rem_d;
      short_valid_q    <= short_valid_d;
      short_vc_q       <= short_vc_d;
      short_dt_q       <= short_dt_d;
      short_field_q    <= short_field_d;
      long_hdr_valid_q <= long_hdr_valid_d;
      long_vc_q        <= long_vc_d;
      long_dt_q        <= long_dt_d;
      long_wc_q        <= long_wc_d;
      payload_q        <= payload_d;
      payload_valid_q  <= payload_valid_d;
      payload_be_q     <= payload_be_d;
    end
  end

  assign short_pkt_valid_o        = short_valid_q;
  assign short_pkt_v_channel_o    = short_vc_q;
  assign short_pkt_data_type_o    = short_dt_q;
  assign short_pkt_data_field_o   = short_field_q;
  assign long_pkt_header_valid_o  = long_hdr_valid_q;
  assign long_pkt_v_channel_o     = long_vc_q;
  assign long_pkt_data_type_o     = long_dt_q;
  assign long_pkt_word_cnt_o      = long_wc_q;
  assign long_pkt_payload_o       = payload_q;
  assign long_pkt_payload_valid_o = payload_valid_q;
  assign long_pkt_payload_be_o    = payload_be_q;

endmodule

// File: tb/tb_csi2_packet_handler.sv
// Scoreboard bench for csi2_packet_handler: stimulus pushes expected events, a negedge monitor pops them.
module tb_csi2_packet_handler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] data = 32'd0;
  logic        err = 1'b0;
  logic        corr = 1'b0;

  logic        short_valid;
  logic [1:0]  short_vc;
  logic [5:0]  short_dt;
  logic [15:0] short_field;
  logic        long_hdr_valid;
  logic [1:0]  long_vc;
  logic [5:0]  long_dt;
  logic [15:0] long_wc;
  logic [31:0] payload;
  logic        payload_valid;
  logic [3:0]  payload_be;

  int checks = 0;
  int errors = 0;

  logic [23:0] short_q[$];  // {vc, dt, field}
  logic [23:0] hdr_q[$];    // {vc, dt, wc}
  logic [35:0] pay_q[$];    // {be, data}

  csi2_packet_handler dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .valid_i                  (valid),
    .data_i                   (data),
    .error_i                  (err),
    .error_corrected_i        (corr),
    .short_pkt_valid_o        (short_valid),
    .short_pkt_v_channel_o    (short_vc),
    .short_pkt_data_type_o    (short_dt),
    .short_pkt_data_field_o   (short_field),
    .long_pkt_header_valid_o  (long_hdr_valid),
    .long_pkt_v_channel_o     (long_vc),
    .long_pkt_data_type_o     (long_dt),
    .long_pkt_word_cnt_o      (long_wc),
    .long_pkt_payload_o       (payload),
    .long_pkt_payload_valid_o (payload_valid),
    .long_pkt_payload_be_o    (payload_be)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented output event must match the head of its queue
  always @(negedge clk) begin
    if (!rst) begin
      if (short_valid) begin
        if (short_q.size() == 0) chk("unexpected_short", 64'd1, 64'd0);
        else chk("short_fields", {40'd0, short_vc, short_dt, short_field}, {40'd0, short_q.pop_front()});
      end
      if (long_hdr_valid) begin
        if (hdr_q.size() == 0) chk("unexpected_long_hdr", 64'd1, 64'd0);
        else chk("long_hdr_fields", {40'd0, long_vc, long_dt, long_wc}, {40'd0, hdr_q.pop_front()});
      end
      if (payload_valid) begin
        if (pay_q.size() == 0) chk("unexpected_payload", 64'd1, 64'd0);
        else chk("payload_be_data", {28'd0, payload_be, payload}, {28'd0, pay_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic e, input logic c);
    @(posedge clk);
    #1;
    valid = 1'b1;
    data  = w;
    err   = e;
    corr  = c;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      valid = 1'b0;
      data  = 32'd0;
      err   = 1'b0;
      corr  = 1'b0;
    end
  endtask

  function automatic logic [31:0] hdr(input logic [1:0] vc, input logic [5:0] dt,
                                      input logic [15:0] f);
    return {vc, dt, f, 8'h00};
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_short_valid"}, {63'd0, short_valid}, 64'd0);
    chk({tag, "_short_fields"}, {40'd0, short_vc, short_dt, short_field}, 64'd0);
    chk({tag, "_long_hdr_valid"}, {63'd0, long_hdr_valid}, 64'd0);
    chk({tag, "_long_fields"}, {40'd0, long_vc, long_dt, long_wc}, 64'd0);
    chk({tag, "_payload"}, {27'd0, payload_valid, payload_be, payload}, 64'd0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Long WC=8 with a gap cycle
    hdr_q.push_back({2'd0, 6'h10, 16'd8});
    send(hdr(2'd0, 6'h10, 16'd8), 1'b0, 1'b0);
    gap(1);
    pay_q.push_back({4'hF, 32'hFFFF_FFFF});
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    pay_q.push_back({4'hF, 32'hFFFF_FFFF});
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    gap(3);
    chk("wc8_payload_idle", {63'd0, payload_valid}, 64'd0);
    chk("wc8_fields_held", {40'd0, long_vc, long_dt, long_wc}, {40'd0, 2'd0, 6'h10, 16'd8});

    // Short packet
    short_q.push_back({2'd1, 6'h00, 16'h1234});
    send(hdr(2'd1, 6'h00, 16'h1234), 1'b0, 1'b0);
    gap(3);
    chk("short_held", {40'd0, short_vc, short_dt, short_field}, {40'd0, 2'd1, 6'h00, 16'h1234});
    chk("short_pulse_low", {63'd0, short_valid}, 64'd0);

    // WC=5, then a header immediately after the last word
    hdr_q.push_back({2'd2, 6'h2A, 16'd5});
    send(hdr(2'd2, 6'h2A, 16'd5), 1'b0, 1'b0);
    pay_q.push_back({4'hF, 32'h1122_3344});
    send(32'h1122_3344, 1'b0, 1'b0);
    pay_q.push_back({4'h1, 32'hAABB_CCDD});
    send(32'hAABB_CCDD, 1'b0, 1'b0);
    short_q.push_back({2'd3, 6'h05, 16'hBEEF});
    send(hdr(2'd3, 6'h05, 16'hBEEF), 1'b0, 1'b0);
    gap(2);

    // Uncorrectable ECC error drops the header, corrected one is accepted
    send(hdr(2'd0, 6'h02, 16'h5555), 1'b1, 1'b0);
    send(hdr(2'd1, 6'h20, 16'd4), 1'b1, 1'b0);
    gap(2);
    chk("ecc_short_unchanged", {40'd0, short_vc, short_dt, short_field},
        {40'd0, 2'd3, 6'h05, 16'hBEEF});
    chk("ecc_long_unchanged", {40'd0, long_vc, long_dt, long_wc}, {40'd0, 2'd2, 6'h2A, 16'd5});
    short_q.push_back({2'd0, 6'h02, 16'h5555});
    send(hdr(2'd0, 6'h02, 16'h5555), 1'b1, 1'b1);
    gap(2);

    // WC=0 long header then a short header
    hdr_q.push_back({2'd1, 6'h12, 16'd0});
    send(hdr(2'd1, 6'h12, 16'd0), 1'b0, 1'b0);
    short_q.push_back({2'd0, 6'h03, 16'h0001});
    send(hdr(2'd0, 6'h03, 16'h0001), 1'b0, 1'b0);
    gap(2);

    // Reset in the middle of a WC=12 packet
    hdr_q.push_back({2'd3, 6'h1E, 16'd12});
    send(hdr(2'd3, 6'h1E, 16'd12), 1'b0, 1'b0);
    pay_q.push_back({4'hF, 32'hCAFE_F00D});
    send(32'hCAFE_F00D, 1'b0, 1'b0);
    gap(1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    short_q.push_back({2'd0, 6'h01, 16'h00AA});
    send(hdr(2'd0, 6'h01, 16'h00AA), 1'b0, 1'b0);
    gap(3);
    chk("post_reset_no_payload", {63'd0, payload_valid}, 64'd0);

    chk("short_q_drained", 64'(short_q.size()), 64'd0);
    chk("hdr_q_drained", 64'(hdr_q.size()), 64'd0);
    chk("pay_q_drained", 64'(pay_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
